mips_lsu: RTL

- Load/store unit between the MIPS datapath and the byte-addressed, big-endian, word-wide data RAM, which has a registered read (1-cycle) and a word-only synchronous write.
- Accepts one memory instruction at a time and handles byte, halfword and word accesses, including LWL and LWR.
- Sub-word stores are done as read-modify-write, because the RAM can only write whole words.
- Returns a formatted load result or an address error to the datapath.

---
 rtl/mips_lsu_pkg.sv | 36 +++
 rtl/mips_lsu_align.sv | 57 +++++
 rtl/mips_lsu.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types and constants for the MIPS load/store unit.
package mips_lsu_pkg;

    // Memory op codes, equal to the low four bits of the MIPS opcode.
    typedef enum logic [3:0] {
        OpLb  = 4'd0,
        OpLh  = 4'd1,
        OpLwl = 4'd2,
        OpLw  = 4'd3,
        OpLbu = 4'd4,
        OpLhu = 4'd5,
        OpLwr = 4'd6,
        OpSb  = 4'd8,
        OpSh  = 4'd9,
        OpSw  = 4'd11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StWrite,
        StResp
    } state_e;

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    localparam logic [1:0] BYTE_LANE_MSB = 2'd0;
    localparam logic [1:0] BYTE_LANE_LSB = 2'd3;
    localparam logic [1:0] HALF_LANE_HI  = 2'd0;
    localparam logic [1:0] HALF_LANE_LO  = 2'd2;

    function automatic logic is_store(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Combinational lane steering: load extract/extend/LWL/LWR merge and
// sub-word store merge into the word read back from RAM.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] rt,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  sh_msb;   // 8*k: distance of byte k from the MSB lane
    logic [4:0]  sh_lsb;   // 8*(3-k): distance of byte k from the LSB lane
    logic [4:0]  sh_half;  // 8*(2-k): distance of halfword k from the low half
    logic [31:0] byte_r;
    logic [31:0] half_r;

    assign sh_msb  = {offset - BYTE_LANE_MSB, 3'b000};
    assign sh_lsb  = {BYTE_LANE_LSB - offset, 3'b000};
    assign sh_half = {HALF_LANE_LO - offset, 3'b000};
    assign byte_r  = mem_word >> sh_lsb;
    assign half_r  = mem_word >> sh_half;

    // Format the load result from the addressed lanes.
    always_comb begin
        load_data = 32'h0;
        case (op)
            OpLb:    load_data = {{24{byte_r[7]}}, byte_r[7:0]};
            OpLbu:   load_data = {24'h0, byte_r[7:0]};
            OpLh:    load_data = {{16{half_r[15]}}, half_r[15:0]};
            OpLhu:   load_data = {16'h0, half_r[15:0]};
            OpLw:    load_data = mem_word;
            // LWL fills from the top; bytes below the loaded ones keep rt.
            OpLwl:   load_data = (mem_word << sh_msb) | (rt & ~(32'hFFFF_FFFF << sh_msb));
            // LWR fills from the bottom; bytes above the loaded ones keep rt.
            OpLwr:   load_data = (mem_word >> sh_lsb) | (rt & ~(32'hFFFF_FFFF >> sh_lsb));
            default: load_data = 32'h0;
        endcase
    end

    // Merge store data into the current RAM word.
    always_comb begin
        store_word = 32'h0;
        case (op)
            OpSb:    store_word = (mem_word & ~(32'hFF00_0000 >> sh_msb))
                                | ({24'h0, wdata[7:0]} << sh_lsb);
            OpSh:    store_word = (mem_word & ~(32'hFFFF_0000 >> sh_msb))
                                | ({16'h0, wdata[15:0]} << sh_half);
            OpSw:    store_word = wdata;
            default: store_word = 32'h0;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: one op at a time against a word-wide, registered-read RAM.
// Sub-word stores are read-modify-write since the RAM only writes whole words.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_err;
    logic        mem_active;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // Address/opcode legality of the op currently offered on the request port.
    always_comb begin
        req_err = 1'b0;
        case (req_op)
            OpLh, OpLhu, OpSh:              req_err = req_addr[0];
            OpLw, OpSw:                     req_err = |req_addr[1:0];
            OpLb, OpLbu, OpSb, OpLwl, OpLwr: req_err = 1'b0;
            default:                        req_err = 1'b1;
        endcase
        if (req_addr >= 32'(MEM_BYTES)) begin
            req_err = 1'b1;
        end
    end

    // Sequencer: accept, RAM read/write phases, one-cycle response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rt_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rt_q    <= req_rt;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                        if (req_err) begin
                            state_q <= StResp;
                        end else if (req_op == OpSw) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                // Sub-word stores skip CAPTURE: mem_rd stays valid into WRITE.
                StRead:    state_q <= is_store(op_q) ? StWrite : StCapture;
                StCapture: begin
                    rdata_q <= load_data;
                    state_q <= StResp;
                end
                StWrite:   state_q <= StResp;
                StResp:    state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    mips_lsu_align u_align (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .mem_word   (mem_rd),
        .rt         (rt_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Port outputs decoded from state and registered data only.
    always_comb begin
        mem_active = (state_q == StRead) || (state_q == StCapture) || (state_q == StWrite);
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid & err_q;
        resp_rdata = resp_valid ? rdata_q : 32'h0;
        mem_addr   = mem_active ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_we     = (state_q == StWrite);
        mem_wd     = mem_we ? store_word : 32'h0;
    end

endmodule
